// File: rtl/audio_adc_rx.sv
`default_nettype none
// ============================================================================
// Module      : audio_adc_rx
// Description : Codec ADC serial receiver (I2S / left-justified) delivering
//               stereo frames as parallel samples with a valid/ack handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module audio_adc_rx #(
    parameter int DATA_W      = 16,
    parameter int I2S_DELAY   = 1,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              aud_bclk,
    input  logic              aud_adclrck,
    input  logic              aud_adcdat,
    input  logic              enable,
    output logic [DATA_W-1:0] sample_l,
    output logic [DATA_W-1:0] sample_r,
    output logic              sample_valid,
    input  logic              sample_ack,
    output logic              overrun,
    output logic [7:0]        cpu_byte
);

    localparam int               c_CNT_W = $clog2(DATA_W + 1);
    localparam logic             c_LJ    = (I2S_DELAY == 0);
    localparam logic [c_CNT_W-1:0] c_START_CNT = c_CNT_W'(c_LJ);
    localparam logic [c_CNT_W-1:0] c_LAST      = c_CNT_W'(DATA_W - 1);
    localparam logic [c_CNT_W-1:0] c_FULL      = c_CNT_W'(DATA_W);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ALIGN = 2'd1,
        S_SHIFT = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    logic [SYNC_STAGES-1:0] r_bclk_sync, r_lrck_sync, r_dat_sync;
    logic                   r_bclk_d, r_lrck_prev, r_chan;
    logic [DATA_W-1:0]      r_shift, r_left_hold;
    logic [c_CNT_W-1:0]     r_cnt;
    state_t                 r_state, w_state_next, w_start_state;

    logic w_bclk, w_lrck, w_dat, w_strobe, w_toggle;
    logic w_start, w_take, w_close_short, w_close_full, w_slot_close, w_commit, w_ack_ok;
    logic [DATA_W-1:0]  w_slot_data;
    logic [c_CNT_W-1:0] w_fill_sh;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_bclk_sync <= '0;
            r_lrck_sync <= '0;
            r_dat_sync  <= '0;
            r_bclk_d    <= 1'b0;
            r_lrck_prev <= 1'b0;
        end else begin
            r_bclk_sync <= {r_bclk_sync[SYNC_STAGES-2:0], aud_bclk};
            r_lrck_sync <= {r_lrck_sync[SYNC_STAGES-2:0], aud_adclrck};
            r_dat_sync  <= {r_dat_sync[SYNC_STAGES-2:0], aud_adcdat};
            r_bclk_d    <= w_bclk;
            if (w_strobe)
                r_lrck_prev <= w_lrck;
        end
    end

    assign w_bclk   = r_bclk_sync[SYNC_STAGES-1];
    assign w_lrck   = r_lrck_sync[SYNC_STAGES-1];
    assign w_dat    = r_dat_sync[SYNC_STAGES-1];
    assign w_strobe = w_bclk & ~r_bclk_d;
    assign w_toggle = w_strobe & (w_lrck ^ r_lrck_prev);
    assign w_start_state = c_LJ ? S_SHIFT : S_ALIGN;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_state <= S_IDLE;
        else
            r_state <= w_state_next;
    end

    // A toggle inside an open slot closes it short and immediately opens the other channel.
    always_comb begin
        w_state_next  = r_state;
        w_start       = 1'b0;
        w_take        = 1'b0;
        w_close_short = 1'b0;
        if (!enable) begin
            w_state_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_toggle && !w_lrck) begin
                        w_start      = 1'b1;
                        w_state_next = w_start_state;
                    end
                end
                S_ALIGN, S_SHIFT: begin
                    if (w_toggle) begin
                        w_close_short = 1'b1;
                        w_start       = 1'b1;
                        w_state_next  = w_start_state;
                    end else if (w_strobe) begin
                        w_take       = 1'b1;
                        w_state_next = (r_cnt == c_LAST) ? S_DRAIN : S_SHIFT;
                    end
                end
                S_DRAIN: begin
                    if (w_toggle) begin
                        w_start      = 1'b1;
                        w_state_next = w_start_state;
                    end
                end
                default: w_state_next = S_IDLE;
            endcase
        end
    end

    assign w_close_full = w_take & (r_cnt == c_LAST);
    assign w_slot_close = w_close_full | w_close_short;
    assign w_fill_sh    = c_FULL - r_cnt;
    assign w_slot_data  = w_close_full ? {r_shift[DATA_W-2:0], w_dat} : (r_shift << w_fill_sh);
    assign w_commit     = w_slot_close & r_chan;
    assign w_ack_ok     = sample_ack & sample_valid;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_shift     <= '0;
            r_cnt       <= '0;
            r_chan      <= 1'b0;
            r_left_hold <= '0;
        end else begin
            if (w_start) begin
                r_chan  <= w_lrck;
                r_shift <= {{(DATA_W-1){1'b0}}, w_dat & c_LJ};
                r_cnt   <= c_START_CNT;
            end else if (w_take) begin
                r_shift <= {r_shift[DATA_W-2:0], w_dat};
                r_cnt   <= r_cnt + c_CNT_W'(1);
            end
            if (w_slot_close && !r_chan)
                r_left_hold <= w_slot_data;
        end
    end

    // An ack in the commit cycle consumes the old frame, so the new one never counts as overrun.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sample_l     <= '0;
            sample_r     <= '0;
            sample_valid <= 1'b0;
            overrun      <= 1'b0;
        end else if (w_commit) begin
            sample_l     <= r_left_hold;
            sample_r     <= w_slot_data;
            sample_valid <= 1'b1;
            if (sample_valid && !sample_ack)
                overrun <= 1'b1;
            else if (w_ack_ok)
                overrun <= 1'b0;
        end else if (w_ack_ok) begin
            sample_valid <= 1'b0;
            overrun      <= 1'b0;
        end
    end

    assign cpu_byte = sample_l[DATA_W-1 -: 8];

endmodule
`default_nettype wire

// File: tb/tb_audio_adc_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_audio_adc_rx
// Description : Directed bench for audio_adc_rx (I2S and left-justified DUTs).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_audio_adc_rx;

    logic clk = 1'b0;
    logic reset, enable, sample_ack, lj_ack;
    logic aud_bclk, aud_adclrck, aud_adcdat;
    logic [15:0] sl, sr, lj_sl, lj_sr;
    logic [7:0]  cb, lj_cb;
    logic        sv, ov, lj_sv, lj_ov;

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    audio_adc_rx #(.DATA_W(16), .I2S_DELAY(1), .SYNC_STAGES(2)) dut (
        .clk(clk), .reset(reset), .aud_bclk(aud_bclk), .aud_adclrck(aud_adclrck),
        .aud_adcdat(aud_adcdat), .enable(enable), .sample_l(sl), .sample_r(sr),
        .sample_valid(sv), .sample_ack(sample_ack), .overrun(ov), .cpu_byte(cb)
    );

    audio_adc_rx #(.DATA_W(16), .I2S_DELAY(0), .SYNC_STAGES(2)) dut_lj (
        .clk(clk), .reset(reset), .aud_bclk(aud_bclk), .aud_adclrck(aud_adclrck),
        .aud_adcdat(aud_adcdat), .enable(enable), .sample_l(lj_sl), .sample_r(lj_sr),
        .sample_valid(lj_sv), .sample_ack(lj_ack), .overrun(lj_ov), .cpu_byte(lj_cb)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One BCLK period (160 ns): falling half drives LRCK/DATA, rising half lets the DUT sample.
    task automatic bclk_cycle(input logic lr, input logic d);
        aud_bclk    = 1'b0;
        aud_adclrck = lr;
        aud_adcdat  = d;
        #80;
        aud_bclk    = 1'b1;
        #80;
    endtask

    task automatic send_slot(input logic lr, input logic [15:0] d, input int bits, input int len,
                             input bit lj, input int from, input int to);
        for (int c = from; c < to && c < len; c++) begin
            int k;
            k = lj ? c : c - 1;
            bclk_cycle(lr, (k >= 0 && k < bits) ? d[15-k] : 1'b0);
        end
    endtask

    task automatic send_frame(input logic [15:0] l, input int lbits, input int llen,
                              input logic [15:0] r, input bit lj);
        send_slot(1'b0, l, lbits, llen, lj, 0, llen);
        send_slot(1'b1, r, 16, 20, lj, 0, 20);
    endtask

    task automatic do_ack(input string tag);
        sample_ack = 1'b1;
        #10;
        sample_ack = 1'b0;
        check({tag, "_valid"}, {15'd0, sv}, 16'd0);
        check({tag, "_ovr"}, {15'd0, ov}, 16'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; enable = 1'b1; sample_ack = 1'b0; lj_ack = 1'b0;
        aud_bclk = 1'b1; aud_adclrck = 1'b1; aud_adcdat = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_l", sl, 16'h0000);
        check("rst_r", sr, 16'h0000);
        check("rst_valid", {15'd0, sv}, 16'd0);
        check("rst_ovr", {15'd0, ov}, 16'd0);
        check("rst_cpu", {8'd0, cb}, 16'd0);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) bclk_cycle(1'b1, 1'b0);

        // Basic I2S frame
        send_frame(16'hA5C3, 16, 20, 16'h0F81, 0);
        check("t1_l", sl, 16'hA5C3);
        check("t1_r", sr, 16'h0F81);
        check("t1_cpu", {8'd0, cb}, 16'h00A5);
        check("t1_valid", {15'd0, sv}, 16'd1);
        check("t1_ovr", {15'd0, ov}, 16'd0);
        do_ack("t1_ack");

        // Three frames without ack
        send_frame(16'h1111, 16, 20, 16'h2222, 0);
        check("t2_f1_valid", {15'd0, sv}, 16'd1);
        check("t2_f1_ovr", {15'd0, ov}, 16'd0);
        send_frame(16'h3333, 16, 20, 16'h4444, 0);
        send_frame(16'h5555, 16, 20, 16'h6666, 0);
        check("t2_l", sl, 16'h5555);
        check("t2_r", sr, 16'h6666);
        check("t2_cpu", {8'd0, cb}, 16'h0055);
        check("t2_valid", {15'd0, sv}, 16'd1);
        check("t2_ovr", {15'd0, ov}, 16'd1);
        do_ack("t2_ack");

        // Ack lands on the commit edge of frame 2 (third posedge after the last right BCLK rise)
        send_frame(16'h1357, 16, 20, 16'h2468, 0);
        check("t3_f1_valid", {15'd0, sv}, 16'd1);
        @(negedge clk);
        fork
            send_frame(16'hAAAA, 16, 20, 16'hBBBB, 0);
            begin
                #((20 + 16) * 160 + 80 + 20);
                sample_ack = 1'b1;
                #10;
                sample_ack = 1'b0;
            end
        join
        check("t3_l", sl, 16'hAAAA);
        check("t3_r", sr, 16'hBBBB);
        check("t3_valid", {15'd0, sv}, 16'd1);
        check("t3_ovr", {15'd0, ov}, 16'd0);
        do_ack("t3_ack");

        // Short left slot of 12 bits
        send_frame(16'hABC0, 12, 13, 16'h1357, 0);
        check("t4_l", sl, 16'hABC0);
        check("t4_r", sr, 16'h1357);
        check("t4_cpu", {8'd0, cb}, 16'h00AB);
        do_ack("t4_ack");

        // Enable dropped after 8 left bits
        send_slot(1'b0, 16'hDEAD, 16, 20, 0, 0, 9);
        enable = 1'b0;
        #30;
        enable = 1'b1;
        send_slot(1'b0, 16'hDEAD, 16, 20, 0, 9, 20);
        send_slot(1'b1, 16'hBEEF, 16, 20, 0, 0, 20);
        check("t5e_valid", {15'd0, sv}, 16'd0);
        check("t5e_l", sl, 16'hABC0);
        send_frame(16'h1234, 16, 20, 16'h5678, 0);
        check("t5e_l2", sl, 16'h1234);
        check("t5e_r2", sr, 16'h5678);
        check("t5e_valid2", {15'd0, sv}, 16'd1);
        check("t5e_ovr2", {15'd0, ov}, 16'd0);
        do_ack("t5e_ack");

        // Reset after 8 left bits
        send_slot(1'b0, 16'hDEAD, 16, 20, 0, 0, 9);
        reset = 1'b1;
        #30;
        reset = 1'b0;
        send_slot(1'b0, 16'hDEAD, 16, 20, 0, 9, 20);
        send_slot(1'b1, 16'hBEEF, 16, 20, 0, 0, 20);
        check("t5r_valid", {15'd0, sv}, 16'd0);
        check("t5r_l", sl, 16'h0000);
        send_frame(16'h1234, 16, 20, 16'h5678, 0);
        check("t5r_l2", sl, 16'h1234);
        check("t5r_r2", sr, 16'h5678);
        check("t5r_valid2", {15'd0, sv}, 16'd1);
        check("t5r_ovr2", {15'd0, ov}, 16'd0);
        do_ack("t5r_ack");

        // Left-justified frame on the I2S_DELAY=0 instance
        send_frame(16'h8001, 16, 20, 16'hFFFF, 1);
        check("t6_l", lj_sl, 16'h8001);
        check("t6_r", lj_sr, 16'hFFFF);
        check("t6_cpu", {8'd0, lj_cb}, 16'h0080);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
`default_nettype wire
